ahb_refill_master: RTL and testbench
====================================

# ahb_refill_master

AHB-Lite read master that fetches one cache line per request as a fixed-length incrementing burst. It sits directly upstream of the I-cache's AHB read-capture stage: it drives `haddr`/`hwrite`/`htrans` onto the bus and returns each completed data beat to the line-fill logic. It does no writes and no address wrapping: every burst is line-aligned.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; the beat stride is 4 bytes.
- `BEATS`, default 4: words per line; a power of two, 2..16.

- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  line-fill request.
- `req_addr`  in  ADDR_W  any byte address inside the line.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid & req_ready`.
- `haddr`  out  ADDR_W  AHB address.
- `htrans`  out  2  IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11.
- `hwrite`  out  1  constant 0.
- `hsize`  out  3  constant 3'b010 (word).
- `hburst`  out  3  3'b011 (INCR4) if BEATS = 4, 3'b101 (INCR8) if 8, 3'b111 (INCR16) if 16; 3'b001 (INCR) if 2.
- `hready`  in  1  slave ready.
- `hrdata`  in  DATA_W  read data.
- `hresp`  in  1  1 = ERROR.
- `beat_valid`  out  1  one-cycle pulse per returned word.
- `beat_data`  out  DATA_W  registered `hrdata`.
- `beat_idx`  out  log2(BEATS)  word index within the line.
- `done`  out  1  one-cycle pulse when the burst ends.
- `err`  out  1  qualifies `done`; 1 = burst aborted by ERROR.

## Operation
- Base address = `req_addr` with the low log2(BEATS)+2 bits cleared, latched on acceptance.
- Address counter `acnt` counts address phases accepted; data counter `dcnt` counts data phases completed.
- States:
  - IDLE: `htrans` = IDLE, `req_ready` = 1. Acceptance moves to ADDR.
  - ADDR: `htrans` = NONSEQ, `haddr` = base. Moves to BURST on `hready`.
  - BURST: while `acnt` < BEATS, drive `htrans` = SEQ and `haddr` = base + 4·`acnt`; after the last address is accepted, drive `htrans` = IDLE. Each `hready` edge with a data phase open and `hresp` = 0 completes one beat.
  - ERR: entered on `hresp` = 1 with `hready` = 0, the first cycle of the ERROR response. `htrans` = IDLE from the next cycle, and no further addresses are issued. Leaves on `hready` = 1, the second cycle, to IDLE with `done` = 1 and `err` = 1.
- No beat is reported for an errored data phase.
- Completed beat: next cycle `beat_valid` = 1, `beat_data` = sampled `hrdata`, `beat_idx` = `dcnt`.
- Last beat: `done` = 1 and `err` = 0 in the same cycle as its `beat_valid`; the state is already IDLE.
- `hready` low holds `haddr`/`htrans` stable and stalls both counters; beats are never duplicated.
- `req_valid` outside IDLE is ignored. A new request may be accepted in the `done` cycle.
- `rstn` low at any time forces IDLE immediately (asynchronous), cancelling any burst with no `done`.

## Timing
- Reset values: `haddr` = 0, `htrans` = 2'b00, `hburst` = 0, `beat_valid` = 0, `beat_data` = 0, `beat_idx` = 0, `done` = 0, `err` = 0, `req_ready` = 1. `hwrite` and `hsize` are constants.
- Zero-wait, BEATS = 4, acceptance in cycle 0:
  - NONSEQ in cycle 1.
  - SEQ in cycles 2–4.
  - `htrans` = IDLE in cycle 5.
  - `beat_valid` in cycles 3–6.
  - `done` in cycle 6; `req_ready` = 1 in cycle 6.
- Minimum request-to-request spacing: BEATS + 2 cycles.
- Each `hready`-low cycle adds one cycle of latency.
- Error: `done`/`err` asserts the cycle after the second ERROR cycle.

## Test plan
- Zero-wait fill, `req_addr` = 0x1000_0014:
  - `haddr` = 0x1000_0010, 14, 18, 1C with NONSEQ, SEQ, SEQ, SEQ, `hburst` = 3'b011.
  - `beat_idx` 0..3 in cycles 3–6; `done` = 1, `err` = 0 in cycle 6.
- `hready` low for 2 cycles during beat 2's data phase:
  - `haddr` holds 0x1000_001C.
  - Exactly 4 `beat_valid` pulses, with data matching the slave words in order.
  - `done` delayed by 2 cycles.
- ERROR response in beat 1's data phase:
  - `htrans` = IDLE from the second error cycle.
  - Only beat 0 is reported; `done` = 1 with `err` = 1; return to IDLE.
- Back-to-back: second `req_valid` held high from cycle 0 → accepted in cycle 6, NONSEQ in cycle 7, no overlap with the first burst.
- `rstn` pulsed low in cycle 3 of a burst → `htrans` = 0, `beat_valid` = 0, `req_ready` = 1 while low; no `done`; a new request after release runs normally.
- BEATS = 8 build → `hburst` = 3'b101, 8 addresses base..base+0x1C, `beat_idx` 0..7.

Source files
------------

// File: rtl/ahb_refill_master.sv
// rtl/ahb_refill_master.sv - AHB-Lite read master fetching one line-aligned incrementing burst per request
module ahb_refill_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     req_ready,
    output logic [ADDR_W-1:0]        haddr,
    output logic [1:0]               htrans,
    output logic                     hwrite,
    output logic [2:0]               hsize,
    output logic [2:0]               hburst,
    input  logic                     hready,
    input  logic [DATA_W-1:0]        hrdata,
    input  logic                     hresp,
    output logic                     beat_valid,
    output logic [DATA_W-1:0]        beat_data,
    output logic [$clog2(BEATS)-1:0] beat_idx,
    output logic                     done,
    output logic                     err
);
    localparam int IW    = $clog2(BEATS);
    localparam int CW    = IW + 1;
    localparam int OFF_W = IW + 2;
    localparam logic [CW-1:0]     BEATS_N   = CW'(BEATS);
    localparam logic [CW-1:0]     LAST_N    = CW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [2:0]        HBURST_C  = (BEATS == 16) ? 3'b111 :
                                              (BEATS == 8)  ? 3'b101 :
                                              (BEATS == 4)  ? 3'b011 : 3'b001;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     acnt, dcnt;
    logic              addr_acc, beat_done, fin_ok, fin_err;
    logic              data_open, addr_left;

    assign hwrite    = 1'b0;
    assign hsize     = 3'b010;
    assign haddr     = base_q | {{(ADDR_W-OFF_W){1'b0}}, acnt[IW-1:0], 2'b00};
    // At most one data phase is ever outstanding, so the counters differ by at most one.
    assign data_open = (dcnt != acnt);
    assign addr_left = (acnt < BEATS_N);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        htrans    = HT_IDLE;
        req_ready = 1'b0;
        addr_acc  = 1'b0;
        beat_done = 1'b0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_ADDR;
            end
            S_ADDR: begin
                htrans = HT_NONSEQ;
                if (hready) begin
                    addr_acc = 1'b1;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (addr_left) htrans = HT_SEQ;
                if (data_open && hresp) begin
                    // A one-cycle ERROR (hready already high) still terminates the burst.
                    if (hready) begin
                        fin_err = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (hready) begin
                    addr_acc = addr_left;
                    if (data_open) begin
                        beat_done = 1'b1;
                        if (dcnt == LAST_N) begin
                            fin_ok  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_ERR: begin
                if (hready) begin
                    fin_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q     <= '0;
            acnt       <= '0;
            dcnt       <= '0;
            hburst     <= 3'b000;
            beat_valid <= 1'b0;
            beat_data  <= '0;
            beat_idx   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            beat_valid <= beat_done;
            done       <= fin_ok | fin_err;
            err        <= fin_err;
            if (req_valid && req_ready) begin
                base_q <= req_addr & LINE_MASK;
                acnt   <= '0;
                dcnt   <= '0;
                hburst <= HBURST_C;
            end
            if (addr_acc) acnt <= acnt + CW'(1);
            if (beat_done) begin
                beat_data <= hrdata;
                beat_idx  <= dcnt[IW-1:0];
                dcnt      <= dcnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ahb_refill_master.sv
// tb/tb_ahb_refill_master.sv - directed bench for ahb_refill_master (BEATS=4 and BEATS=8 instances)
module tb_ahb_refill_master;
    logic        clk;
    logic        rstn;
    logic        hready, hresp;
    logic        req_valid, req_valid8;
    logic [31:0] req_addr, req_addr8;

    logic        req_ready, req_ready8;
    logic [31:0] haddr, haddr8;
    logic [1:0]  htrans, htrans8;
    logic        hwrite, hwrite8;
    logic [2:0]  hsize, hsize8, hburst, hburst8;
    logic [31:0] hrdata, hrdata8;
    logic        beat_valid, beat_valid8;
    logic [31:0] beat_data, beat_data8;
    logic [1:0]  beat_idx;
    logic [2:0]  beat_idx8;
    logic        done, done8, err, err8;

    logic [31:0] dph4, dph8;
    logic [31:0] exp_base;
    logic        rst_drv, sel8;
    int          n_chk, n_pass;

    ahb_refill_master #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hready(hready), .hrdata(hrdata), .hresp(hresp), .beat_valid(beat_valid),
        .beat_data(beat_data), .beat_idx(beat_idx), .done(done), .err(err)
    );

    ahb_refill_master #(.ADDR_W(32), .DATA_W(32), .BEATS(8)) dut8 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid8), .req_addr(req_addr8), .req_ready(req_ready8),
        .haddr(haddr8), .htrans(htrans8), .hwrite(hwrite8), .hsize(hsize8), .hburst(hburst8),
        .hready(hready), .hrdata(hrdata8), .hresp(hresp), .beat_valid(beat_valid8),
        .beat_data(beat_data8), .beat_idx(beat_idx8), .done(done8), .err(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: read data is a fixed scramble of the address whose data phase is open.
    always @(posedge clk) begin
        if (hready && htrans[1])  dph4 <= haddr;
        if (hready && htrans8[1]) dph8 <= haddr8;
    end
    assign hrdata  = dph4 ^ 32'hC3C3_5A5A;
    assign hrdata8 = dph8 ^ 32'hC3C3_5A5A;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    task automatic drive(input logic rv, input logic [31:0] a, input logic hr, input logic hp);
        @(posedge clk);
        #1;
        rstn       = rst_drv;
        req_valid  = rv & ~sel8;
        req_valid8 = rv & sel8;
        req_addr   = a;
        req_addr8  = a;
        hready     = hr;
        hresp      = hp;
        @(negedge clk);
    endtask

    task automatic expect_cyc(input string tag, input logic [1:0] tr, input logic [31:0] ad,
                              input logic bv, input int idx, input logic dn, input logic er,
                              input logic rr);
        logic [1:0]  o_tr;
        logic [31:0] o_ad, o_bd, want_d;
        logic        o_bv, o_dn, o_er, o_rr;
        int          o_idx;
        o_tr  = sel8 ? htrans8     : htrans;
        o_ad  = sel8 ? haddr8      : haddr;
        o_bv  = sel8 ? beat_valid8 : beat_valid;
        o_bd  = sel8 ? beat_data8  : beat_data;
        o_idx = sel8 ? int'(beat_idx8) : int'(beat_idx);
        o_dn  = sel8 ? done8       : done;
        o_er  = sel8 ? err8        : err;
        o_rr  = sel8 ? req_ready8  : req_ready;
        want_d = (exp_base + 32'(4 * idx)) ^ 32'hC3C3_5A5A;
        check($sformatf("%s.htrans", tag), o_tr, tr);
        if (tr != 2'b00) check($sformatf("%s.haddr", tag), o_ad, ad);
        check($sformatf("%s.beat_valid", tag), o_bv, bv);
        if (bv) begin
            check($sformatf("%s.beat_idx", tag), o_idx, idx);
            check($sformatf("%s.beat_data", tag), o_bd, want_d);
        end
        check($sformatf("%s.done", tag), o_dn, dn);
        if (dn) check($sformatf("%s.err", tag), o_er, er);
        check($sformatf("%s.req_ready", tag), o_rr, rr);
    endtask

    task automatic zero_wait_fill(input string tag, input logic [31:0] a, input logic [31:0] b);
        exp_base = b;
        drive(1'b1, a, 1'b1, 1'b0); expect_cyc($sformatf("%s.c0", tag), 2'b00, 32'h0, 0, 0, 0, 0, 1);
        drive(1'b0, a, 1'b1, 1'b0); expect_cyc($sformatf("%s.c1", tag), 2'b10, b, 0, 0, 0, 0, 0);
        check($sformatf("%s.hburst", tag), hburst, 3'b011);
        drive(1'b0, a, 1'b1, 1'b0); expect_cyc($sformatf("%s.c2", tag), 2'b11, b + 32'h4, 0, 0, 0, 0, 0);
        drive(1'b0, a, 1'b1, 1'b0); expect_cyc($sformatf("%s.c3", tag), 2'b11, b + 32'h8, 1, 0, 0, 0, 0);
        drive(1'b0, a, 1'b1, 1'b0); expect_cyc($sformatf("%s.c4", tag), 2'b11, b + 32'hC, 1, 1, 0, 0, 0);
        drive(1'b0, a, 1'b1, 1'b0); expect_cyc($sformatf("%s.c5", tag), 2'b00, 32'h0, 1, 2, 0, 0, 0);
        drive(1'b0, a, 1'b1, 1'b0); expect_cyc($sformatf("%s.c6", tag), 2'b00, 32'h0, 1, 3, 1, 0, 1);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rstn = 1'b0; rst_drv = 1'b0; sel8 = 1'b0;
        req_valid = 1'b0; req_valid8 = 1'b0; req_addr = '0; req_addr8 = '0;
        hready = 1'b1; hresp = 1'b0; exp_base = '0;
        repeat (3) @(negedge clk);
        check("rst.haddr", haddr, 32'h0);
        check("rst.htrans", htrans, 2'b00);
        check("rst.hburst", hburst, 3'b000);
        check("rst.beat_valid", beat_valid, 1'b0);
        check("rst.beat_data", beat_data, 32'h0);
        check("rst.beat_idx", beat_idx, 2'd0);
        check("rst.done", done, 1'b0);
        check("rst.err", err, 1'b0);
        check("rst.req_ready", req_ready, 1'b1);
        check("rst.hwrite", hwrite, 1'b0);
        check("rst.hsize", hsize, 3'b010);

        rst_drv = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        zero_wait_fill("t1", 32'h1000_0014, 32'h1000_0010);

        exp_base = 32'h2000_0030;
        drive(1'b1, 32'h2000_0038, 1'b1, 1'b0); expect_cyc("t2.c0", 2'b00, 32'h0, 0, 0, 0, 0, 1);
        drive(1'b0, 32'h2000_0038, 1'b1, 1'b0); expect_cyc("t2.c1", 2'b10, 32'h2000_0030, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h2000_0038, 1'b1, 1'b0); expect_cyc("t2.c2", 2'b11, 32'h2000_0034, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h2000_0038, 1'b1, 1'b0); expect_cyc("t2.c3", 2'b11, 32'h2000_0038, 1, 0, 0, 0, 0);
        drive(1'b0, 32'h2000_0038, 1'b0, 1'b0); expect_cyc("t2.c4", 2'b11, 32'h2000_003C, 1, 1, 0, 0, 0);
        drive(1'b0, 32'h2000_0038, 1'b0, 1'b0); expect_cyc("t2.c5", 2'b11, 32'h2000_003C, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h2000_0038, 1'b1, 1'b0); expect_cyc("t2.c6", 2'b11, 32'h2000_003C, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h2000_0038, 1'b1, 1'b0); expect_cyc("t2.c7", 2'b00, 32'h0, 1, 2, 0, 0, 0);
        drive(1'b0, 32'h2000_0038, 1'b1, 1'b0); expect_cyc("t2.c8", 2'b00, 32'h0, 1, 3, 1, 0, 1);

        exp_base = 32'h3000_0000;
        drive(1'b1, 32'h3000_0004, 1'b1, 1'b0); expect_cyc("t3.c0", 2'b00, 32'h0, 0, 0, 0, 0, 1);
        drive(1'b0, 32'h3000_0004, 1'b1, 1'b0); expect_cyc("t3.c1", 2'b10, 32'h3000_0000, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h3000_0004, 1'b1, 1'b0); expect_cyc("t3.c2", 2'b11, 32'h3000_0004, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h3000_0004, 1'b0, 1'b1); expect_cyc("t3.c3", 2'b11, 32'h3000_0008, 1, 0, 0, 0, 0);
        drive(1'b0, 32'h3000_0004, 1'b1, 1'b1); expect_cyc("t3.c4", 2'b00, 32'h0, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h3000_0004, 1'b1, 1'b0); expect_cyc("t3.c5", 2'b00, 32'h0, 0, 0, 1, 1, 1);
        drive(1'b0, 32'h3000_0004, 1'b1, 1'b0); expect_cyc("t3.c6", 2'b00, 32'h0, 0, 0, 0, 0, 1);

        exp_base = 32'h1000_0000;
        drive(1'b1, 32'h1000_0000, 1'b1, 1'b0); expect_cyc("t4.c0", 2'b00, 32'h0, 0, 0, 0, 0, 1);
        drive(1'b1, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c1", 2'b10, 32'h1000_0000, 0, 0, 0, 0, 0);
        drive(1'b1, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c2", 2'b11, 32'h1000_0004, 0, 0, 0, 0, 0);
        drive(1'b1, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c3", 2'b11, 32'h1000_0008, 1, 0, 0, 0, 0);
        drive(1'b1, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c4", 2'b11, 32'h1000_000C, 1, 1, 0, 0, 0);
        drive(1'b1, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c5", 2'b00, 32'h0, 1, 2, 0, 0, 0);
        drive(1'b1, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c6", 2'b00, 32'h0, 1, 3, 1, 0, 1);
        exp_base = 32'h4000_0020;
        drive(1'b0, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c7", 2'b10, 32'h4000_0020, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c8", 2'b11, 32'h4000_0024, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c9", 2'b11, 32'h4000_0028, 1, 0, 0, 0, 0);
        drive(1'b0, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c10", 2'b11, 32'h4000_002C, 1, 1, 0, 0, 0);
        drive(1'b0, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c11", 2'b00, 32'h0, 1, 2, 0, 0, 0);
        drive(1'b0, 32'h4000_0024, 1'b1, 1'b0); expect_cyc("t4.c12", 2'b00, 32'h0, 1, 3, 1, 0, 1);

        exp_base = 32'h5000_0000;
        drive(1'b1, 32'h5000_0000, 1'b1, 1'b0); expect_cyc("t5.c0", 2'b00, 32'h0, 0, 0, 0, 0, 1);
        drive(1'b0, 32'h5000_0000, 1'b1, 1'b0); expect_cyc("t5.c1", 2'b10, 32'h5000_0000, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h5000_0000, 1'b1, 1'b0); expect_cyc("t5.c2", 2'b11, 32'h5000_0004, 0, 0, 0, 0, 0);
        rst_drv = 1'b0;
        drive(1'b0, 32'h5000_0000, 1'b1, 1'b0); expect_cyc("t5.c3", 2'b00, 32'h0, 0, 0, 0, 0, 1);
        check("t5.c3.haddr", haddr, 32'h0);
        drive(1'b0, 32'h5000_0000, 1'b1, 1'b0); expect_cyc("t5.c4", 2'b00, 32'h0, 0, 0, 0, 0, 1);
        rst_drv = 1'b1;
        drive(1'b0, 32'h5000_0000, 1'b1, 1'b0); expect_cyc("t5.c5", 2'b00, 32'h0, 0, 0, 0, 0, 1);
        drive(1'b0, 32'h5000_0000, 1'b1, 1'b0); expect_cyc("t5.c6", 2'b00, 32'h0, 0, 0, 0, 0, 1);
        zero_wait_fill("t5b", 32'h6000_0008, 32'h6000_0000);

        sel8 = 1'b1;
        exp_base = 32'h7000_0020;
        for (int k = 0; k <= 10; k++) begin
            logic [1:0] tr;
            tr = (k == 0 || k >= 9) ? 2'b00 : (k == 1) ? 2'b10 : 2'b11;
            drive(k == 0, 32'h7000_0034, 1'b1, 1'b0);
            expect_cyc($sformatf("t6.c%0d", k), tr, 32'h7000_0020 + 32'(4 * (k - 1)),
                       k >= 3, (k >= 3) ? k - 3 : 0, k == 10, 1'b0, k == 0 || k == 10);
            if (k == 1) check("t6.hburst", hburst8, 3'b101);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
